wb_initiator: RTL and testbench
===============================

Name: wb_initiator

Overview:
- Wishbone classic single-transfer bus master (initiator); the counterpart of the team's Wishbone memory responder.
- Accepts byte/half/word load-store requests from the core's load-store unit on a valid/ready interface.
- Generates cyc/stb/we/adr/sel/dat with byte-lane steering, waits for ack, then returns lane-extracted, sign- or zero-extended read data on a valid/ready response channel.
- Sits between the CPU core and the shared Wishbone bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUS state before abort. Used only when WB_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  load result is sign-extended when 1, zero-extended when 0
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or timeout
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  30  word address = req_addr[31:2]
- sel_o  out  4  byte-lane select
- dat_o  out  32  lane-steered write data
- dat_i  in  32  read data from responder
- ack_i  in  1  responder acknowledge

Behaviour:
- Reset values: cyc_o, stb_o, we_o, rsp_valid, rsp_err = 0; adr_o, sel_o, dat_o, rsp_rdata = 0; state = IDLE.
- All outputs are registered except req_ready.
- The FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request.
  - Error conditions: misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or req_size=3. On an error, go to RESP with rsp_err=1 and issue no bus cycle.
  - Otherwise go to BUS with cyc_o = stb_o = 1 and we_o = req_we.
- sel_o generation:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- dat_o generation: req_wdata replicated into lanes (byte x4, half x2, word as-is). Lanes not selected are don't-care.
- BUS:
  - Hold all bus outputs stable until ack_i is sampled high.
  - On ack_i: clear cyc_o and stb_o in the same edge and go to RESP.
  - For loads, the selected lanes of dat_i are shifted right by addr[1:0]*8. The result is extended from 8 or 16 bits per req_signed and registered into rsp_rdata.
- RESP:
  - rsp_valid = 1; hold rsp_rdata and rsp_err stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
- Bus spacing: cyc_o/stb_o are low for at least 2 cycles between consecutive transfers (RESP plus IDLE). This is required because the responder's ack derives from a registered "serviced" flag that clears one cycle after stb falls.
- Latency: request accepted at edge N; stb_o high from N+1; with a one-wait responder, ack is seen at N+2 and rsp_valid is high from N+3.
- ack_i in IDLE or RESP is ignored.
- Asynchronous reset mid-BUS: cyc_o and stb_o drop immediately and the in-flight request is discarded with no response.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ack_i.
  - When the counter reaches TIMEOUT_CYCLES: drop cyc_o/stb_o, go to RESP with rsp_err=1 and rsp_rdata=0.
  - ack_i on the same cycle as the limit takes priority and gives a normal completion.
- When undefined: no counter exists and BUS waits indefinitely.

Test Plan:
- Word load, preload word 0 = 0xDEAD8FF1: req addr 0x0, size 2 → adr_o=0, sel_o=4'b1111, rsp_rdata=0xDEAD8FF1, rsp_err=0, rsp_valid 3 cycles after acceptance.
- Byte load signed/unsigned, addr 0x1 → sel_o=4'b0010; signed gives 0xFFFFFF8F, unsigned gives 0x0000008F.
- Half store 0xBEEF to 0x142, then word load from 0x140, preload word 80 = 0x88776655:
  - store drives adr_o=80, sel_o=4'b1100, dat_o[31:16]=0xBEEF
  - load returns 0xBEEF6655
- Misaligned and illegal requests → rsp_err=1, rsp_rdata=0, cyc_o never asserted:
  - half at 0x3
  - word at 0x2
  - size=3
- Back-to-back loads with rsp_ready tied high → exactly one ack per transfer, stb_o low for ≥2 cycles between transfers, both results correct.
- Stall and reset:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0.
  - Assert sys_rst_n=0 mid-BUS → cyc_o=0 with no clock edge needed.
  - With WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never asserted → rsp_err=1 after 4 BUS cycles.

Source files
------------

// File: rtl/wb_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Brief    : Wishbone classic single-transfer initiator with byte-lane steering
//            and sign/zero-extended load return. Optional bus timeout is
//            enabled by defining WB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [29:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [29:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic        sgn_q, sgn_d;

    logic        req_err;
    logic        tmo_hit;
    logic [31:0] rd_shift;
    logic [31:0] load_data;
    logic [3:0]  sel_new;
    logic [31:0] dat_new;

    assign req_err = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

`ifdef WB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Counter is zero whenever outside BUS, so it starts at zero on entry.
    always_comb tmo_cnt_d = (state_q == S_BUS) ? tmo_cnt_q + 16'd1 : 16'd0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tmo_cnt_q <= 16'd0;
        else            tmo_cnt_q <= tmo_cnt_d;
    end

    assign tmo_hit = (state_q == S_BUS) && !ack_i && (tmo_cnt_q + 16'd1 == TMO_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        rd_shift = dat_i >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_data = sgn_q ? {{24{rd_shift[7]}},  rd_shift[7:0]}
                                       : {24'd0, rd_shift[7:0]};
            2'd1:    load_data = sgn_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                       : {16'd0, rd_shift[15:0]};
            default: load_data = dat_i;
        endcase
    end

    always_comb begin
        case (req_size)
            2'd0:    begin sel_new = 4'b0001 << req_addr[1:0]; dat_new = {4{req_wdata[7:0]}};  end
            2'd1:    begin sel_new = 4'b0011 << req_addr[1:0]; dat_new = {2{req_wdata[15:0]}}; end
            default: begin sel_new = 4'b1111;                  dat_new = req_wdata;            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 30'd0;
            sel_q       <= 4'd0;
            dat_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            size_q      <= 2'd0;
            off_q       <= 2'd0;
            sgn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sgn_q       <= sgn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)          state_d = req_err ? S_RESP : S_BUS;
            S_BUS:   if (ack_i || tmo_hit)   state_d = S_RESP;
            S_RESP:  if (rsp_ready)          state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        size_d      = size_q;
        off_d       = off_q;
        sgn_d       = sgn_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    adr_d  = req_addr[31:2];
                    off_d  = req_addr[1:0];
                    size_d = req_size;
                    sgn_d  = req_signed;
                    sel_d  = sel_new;
                    dat_d  = dat_new;
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        cyc_d = 1'b1;
                        stb_d = 1'b1;
                        we_d  = req_we;
                    end
                end
            end
            S_BUS: begin
                // Ack wins over a timeout landing on the same cycle.
                if (ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'd0 : load_data;
                end else if (tmo_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign sel_o     = sel_q;
    assign dat_o     = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_initiator
// Brief    : Self-checking bench for wb_initiator against a byte-addressed
//            memory reference model, with a wait-state Wishbone responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;

    localparam int TMO = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_err, cyc_o, stb_o, we_o;
    logic [31:0] rsp_rdata, dat_o, dat_i;
    logic [29:0] adr_o;
    logic [3:0]  sel_o;
    logic        ack_i = 1'b0;

    always #5 sys_clk = ~sys_clk;

    wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i)
    );

    // Responder: word memory, ack after xwait_cfg extra cycles, one ack per strobe.
    logic [31:0] bus_mem [0:255];
    bit          ack_en = 1'b1;
    int          xwait_cfg = 0;
    int          wait_left = 0;
    assign dat_i = bus_mem[adr_o[7:0]];

    always @(posedge sys_clk) begin
        if (cyc_o && stb_o && ack_en && !ack_i) begin
            if (wait_left == 0) ack_i <= 1'b1;
            else                wait_left <= wait_left - 1;
        end else begin
            ack_i     <= 1'b0;
            wait_left <= xwait_cfg;
        end
        if (ack_i && cyc_o && stb_o && we_o)
            for (int b = 0; b < 4; b++)
                if (sel_o[b]) bus_mem[adr_o[7:0]][8*b +: 8] <= dat_o[8*b +: 8];
    end

    // Bus monitor: strobe cycles, acks, idle gaps, stability while strobed.
    int          mon_stb_cycles = 0, mon_acks = 0, mon_gap_viol = 0;
    int          mon_unstable = 0, mon_cycstb = 0, mon_gap = 10;
    bit          mon_prev = 1'b0, mon_seen = 1'b0;
    logic [29:0] cap_adr = '0;
    logic [3:0]  cap_sel = '0;
    logic [31:0] cap_dat = '0;
    logic        cap_we = 1'b0;

    always @(posedge sys_clk) begin
        mon_prev <= cyc_o && stb_o;
        if (cyc_o != stb_o) mon_cycstb <= mon_cycstb + 1;
        if (cyc_o && stb_o) begin
            mon_stb_cycles <= mon_stb_cycles + 1;
            mon_gap        <= 0;
            if (ack_i) mon_acks <= mon_acks + 1;
            if (!mon_prev) begin
                cap_adr  <= adr_o;
                cap_sel  <= sel_o;
                cap_dat  <= dat_o;
                cap_we   <= we_o;
                mon_seen <= 1'b1;
                if (mon_seen && mon_gap < 2) mon_gap_viol <= mon_gap_viol + 1;
            end else if ({adr_o, sel_o, dat_o, we_o} != {cap_adr, cap_sel, cap_dat, cap_we}) begin
                mon_unstable <= mon_unstable + 1;
            end
        end else if (mon_gap < 100) begin
            mon_gap <= mon_gap + 1;
        end
    end

    // Reference model: byte-addressed little-endian memory.
    logic [7:0] model_mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        int n = 1 << size;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v |= 32'(model_mem[int'(addr[9:0]) + i]) << (8 * i);
        if (sgn && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic set_word(input int w, input logic [31:0] val);
        bus_mem[w] = val;
        for (int i = 0; i < 4; i++) model_mem[4*w + i] = val[8*i +: 8];
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wdata, input int xwait,
                          input int stall, input bit rdy_high, output logic [31:0] rdata);
        int stb0, ack0, idx, n;
        bit err_exp;
        logic [31:0] exp_data, lane_mask, exp_lanes;
        logic [3:0] exp_sel;
        err_exp   = is_err(addr, size);
        n         = 1 << size;
        exp_data  = (err_exp || we) ? 32'd0 : model_load(addr, size, sgn);
        exp_sel   = '0;
        lane_mask = '0;
        exp_lanes = '0;
        if (!err_exp) begin
            for (int i = 0; i < n; i++) begin
                int lane = int'(addr[1:0]) + i;
                exp_sel[lane]          = 1'b1;
                lane_mask[8*lane +: 8] = 8'hFF;
                exp_lanes[8*lane +: 8] = wdata[8*i +: 8];
                if (we) model_mem[int'(addr[9:0]) + i] = wdata[8*i +: 8];
            end
        end
        stb0 = mon_stb_cycles;
        ack0 = mon_acks;
        xwait_cfg  = xwait;
        rsp_ready  = rdy_high;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        idx = 1;
        while (!rsp_valid && idx < 64) begin
            @(posedge sys_clk); #1;
            idx++;
        end
        check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        check("latency", idx, err_exp ? 32'd1 : 32'(3 + xwait));
        check("rsp_err", {31'd0, rsp_err}, {31'd0, err_exp});
        check("rsp_rdata", rsp_rdata, exp_data);
        rdata = rsp_rdata;
        if (!rdy_high) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge sys_clk); #1;
                check("stall_flags", {29'd0, rsp_valid, rsp_err, req_ready}, {29'd0, 1'b1, err_exp, 1'b0});
                check("stall_rdata", rsp_rdata, exp_data);
            end
        end
        rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        rsp_ready = rdy_high;
        check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        check("stb_cycles", mon_stb_cycles - stb0, err_exp ? 32'd0 : 32'(2 + xwait));
        check("ack_count", mon_acks - ack0, err_exp ? 32'd0 : 32'd1);
        if (!err_exp) begin
            check("adr_o", {2'b00, cap_adr}, {2'b00, addr[31:2]});
            check("sel_o", {28'd0, cap_sel}, {28'd0, exp_sel});
            check("we_o", {31'd0, cap_we}, {31'd0, we});
            if (we) check("dat_o_lanes", cap_dat & lane_mask, exp_lanes);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int idx;
        for (int w = 0; w < 256; w++) set_word(w, $urandom);
        set_word(0, 32'hDEAD_8FF1);
        set_word(80, 32'h8877_6655);

        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_outs", {29'd0, cyc_o, stb_o, we_o} | {31'd0, rsp_valid} | {31'd0, rsp_err}
                            | {2'd0, adr_o} | {28'd0, sel_o} | dat_o | rsp_rdata, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        do_txn(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0, 1'b0, rd);
        check("word_load", rd, 32'hDEAD_8FF1);
        do_txn(1'b0, 32'h1, 2'd0, 1'b1, 32'h0, 0, 0, 1'b0, rd);
        check("byte_load_signed", rd, 32'hFFFF_FF8F);
        do_txn(1'b0, 32'h1, 2'd0, 1'b0, 32'h0, 1, 0, 1'b0, rd);
        check("byte_load_unsigned", rd, 32'h0000_008F);
        do_txn(1'b1, 32'h142, 2'd1, 1'b0, 32'h0000_BEEF, 0, 0, 1'b0, rd);
        check("half_store_sel", {28'd0, cap_sel}, 32'hC);
        check("half_store_dat", {16'd0, cap_dat[31:16]}, 32'h0000_BEEF);
        do_txn(1'b0, 32'h140, 2'd2, 1'b0, 32'h0, 0, 0, 1'b0, rd);
        check("word_after_half_store", rd, 32'hBEEF_6655);

        do_txn(1'b0, 32'h3, 2'd1, 1'b0, 32'h0, 0, 0, 1'b0, rd);
        do_txn(1'b1, 32'h2, 2'd2, 1'b0, 32'h1234_5678, 0, 0, 1'b0, rd);
        do_txn(1'b0, 32'h8, 2'd3, 1'b0, 32'h0, 0, 0, 1'b0, rd);

        do_txn(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0, 1'b1, rd);
        do_txn(1'b0, 32'h142, 2'd1, 1'b1, 32'h0, 0, 0, 1'b1, rd);
        check("b2b_second", rd, 32'hFFFF_BEEF);
        rsp_ready = 1'b0;

        do_txn(1'b0, 32'h140, 2'd2, 1'b0, 32'h0, 2, 5, 1'b0, rd);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            bit          hi;
            a  = 32'($urandom_range(0, 1023));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            hi = 1'($urandom_range(0, 1));
            do_txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), hi, rd);
            rsp_ready = 1'b0;
        end

        // Reset while the bus cycle is outstanding.
        ack_en    = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_size  = 2'd2;
        req_valid = 1'b1;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        check("bus_cyc_up", {30'd0, cyc_o, stb_o}, 32'd3);
        @(posedge sys_clk);
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b0;
        #1;
        check("rst_async_cyc", {30'd0, cyc_o, stb_o}, 32'd0);
        check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("post_rst_idle", {29'd0, rsp_valid, cyc_o, req_ready}, 32'd1);

`ifdef WB_TIMEOUT_EN
        begin
            int stb0;
            ack_en    = 1'b0;
            stb0      = mon_stb_cycles;
            req_we    = 1'b0;
            req_addr  = 32'h20;
            req_size  = 2'd2;
            req_valid = 1'b1;
            @(posedge sys_clk); #1;
            req_valid = 1'b0;
            idx = 1;
            while (!rsp_valid && idx < 64) begin
                @(posedge sys_clk); #1;
                idx++;
            end
            check("tmo_latency", idx, 32'(TMO + 1));
            check("tmo_err", {31'd0, rsp_err}, 32'd1);
            check("tmo_rdata", rsp_rdata, 32'd0);
            check("tmo_cyc_low", {31'd0, cyc_o}, 32'd0);
            check("tmo_stb_cycles", mon_stb_cycles - stb0, 32'(TMO));
            rsp_ready = 1'b1;
            @(posedge sys_clk); #1;
            rsp_ready = 1'b0;
            ack_en = 1'b1;
        end
`endif

        check("stb_gap", mon_gap_viol, 32'd0);
        check("bus_stable", mon_unstable, 32'd0);
        check("cyc_eq_stb", mon_cycstb, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
